// File: rtl/k_and_s_pkg.sv
// Shared encodings for the K&S 16-bit processor: instruction classes,
// control-unit states, ALU operation codes and small decode helpers.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_HALT   = 4'd13
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        INIT    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        LOAD_1  = 4'd3,
        LOAD_2  = 4'd4,
        STORE_1 = 4'd5,
        STORE_2 = 4'd6,
        MOVE    = 4'd7,
        ALU     = 4'd8,
        BRANCH  = 4'd9,
        HALT    = 4'd10
    } ctrl_state_type;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    function automatic logic [1:0] alu_operation(input decoded_instruction_type instr);
        logic [1:0] op;
        case (instr)
            I_ADD:   op = OP_ADD;
            I_SUB:   op = OP_SUB;
            I_AND:   op = OP_AND;
            default: op = OP_OR;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input decoded_instruction_type instr,
                                          input logic zero, input logic neg);
        logic taken;
        case (instr)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero;
            I_BNZERO: taken = ~zero;
            I_BNEG:   taken = neg;
            I_BNNEG:  taken = ~neg;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/k_and_s_control_unit_if.sv
// Control/status bundle between the K&S control unit (master) and data path (slave).
interface k_and_s_control_unit_if;

    k_and_s_pkg::decoded_instruction_type decoded_instruction;
    logic       zero_op;
    logic       neg_op;
    logic       unsigned_overflow;
    logic       signed_overflow;
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt
    );

endinterface

// File: rtl/k_and_s_control_unit.sv
// Control FSM for the K&S processor: sequences fetch, decode and execute and
// drives every data-path strobe from the current state.
module k_and_s_control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    k_and_s_control_unit_if.master  bus
);

    ctrl_state_type state, state_next;

    // Overflow flags travel with the bundle for the top level but never steer control.
    logic unused_overflow;
    assign unused_overflow = bus.unsigned_overflow ^ bus.signed_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = FETCH;
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (bus.decoded_instruction)
                    I_LOAD:   state_next = LOAD_1;
                    I_STORE:  state_next = STORE_1;
                    I_MOVE:   state_next = MOVE;
                    I_ADD, I_SUB, I_AND, I_OR:
                              state_next = ALU;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG:
                              state_next = BRANCH;
                    I_HALT:   state_next = HALT;
                    default:  state_next = FETCH;
                endcase
            end
            LOAD_1:  state_next = LOAD_2;
            LOAD_2:  state_next = FETCH;
            STORE_1: state_next = STORE_2;
            STORE_2: state_next = FETCH;
            MOVE, ALU, BRANCH:
                     state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        bus.branch           = 1'b0;
        bus.pc_enable        = 1'b0;
        bus.ir_enable        = 1'b0;
        bus.addr_sel         = 1'b0;
        bus.c_sel            = 1'b0;
        bus.operation        = OP_OR;
        bus.write_reg_enable = 1'b0;
        bus.flags_reg_enable = 1'b0;
        bus.ram_write_enable = 1'b0;
        bus.halt             = 1'b0;
        case (state)
            FETCH: begin
                bus.addr_sel  = 1'b1;
                bus.ir_enable = 1'b1;
            end
            DECODE:  bus.pc_enable = 1'b1;
            LOAD_2: begin
                bus.c_sel            = 1'b1;
                bus.write_reg_enable = 1'b1;
            end
            STORE_2: bus.ram_write_enable = 1'b1;
            MOVE:    bus.write_reg_enable = 1'b1;
            ALU: begin
                bus.operation        = alu_operation(bus.decoded_instruction);
                bus.write_reg_enable = 1'b1;
                bus.flags_reg_enable = 1'b1;
            end
            // A not-taken branch leaves the PC+1 value loaded during DECODE.
            BRANCH: begin
                if (branch_taken(bus.decoded_instruction, bus.zero_op, bus.neg_op)) begin
                    bus.branch    = 1'b1;
                    bus.pc_enable = 1'b1;
                end
            end
            HALT:    bus.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_k_and_s_control_unit.sv
// Table-driven bench for the K&S control unit: per-instruction output sequences
// plus hand-written reset, store-abort and halt sequences.
module tb_k_and_s_control_unit;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    k_and_s_control_unit_if bus ();

    k_and_s_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        string                   name;
        decoded_instruction_type instr;
        logic                    z;
        logic                    n;
        int                      ncyc;
        logic [3:0][10:0]        exp;
    } vec_t;

    vec_t vecs[16];
    int   nv = 0;
    int   checks = 0;
    int   errors = 0;

    // {branch, pc_enable, ir_enable, addr_sel, c_sel, operation[1:0], wr, flags, ram_we, halt}
    function automatic logic [10:0] mk(logic br, logic pc, logic ir, logic ad, logic cs,
                                       logic [1:0] op, logic wr, logic fl, logic rw, logic h);
        return {br, pc, ir, ad, cs, op, wr, fl, rw, h};
    endfunction

    function automatic logic [10:0] outs();
        return {bus.branch, bus.pc_enable, bus.ir_enable, bus.addr_sel, bus.c_sel,
                bus.operation, bus.write_reg_enable, bus.flags_reg_enable,
                bus.ram_write_enable, bus.halt};
    endfunction

    logic [10:0] O_NONE, O_FETCH, O_DECODE, O_LOAD2, O_STORE2, O_MOVE, O_BR, O_HALT;

    task automatic check(input string nm, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic add(input string nm, input decoded_instruction_type ins, input logic z,
                       input logic n, input int nc, input logic [10:0] e2, input logic [10:0] e3);
        vecs[nv].name  = nm;
        vecs[nv].instr = ins;
        vecs[nv].z     = z;
        vecs[nv].n     = n;
        vecs[nv].ncyc  = nc;
        vecs[nv].exp[0] = O_FETCH;
        vecs[nv].exp[1] = O_DECODE;
        vecs[nv].exp[2] = e2;
        vecs[nv].exp[3] = e3;
        nv++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        O_NONE   = '0;
        O_FETCH  = mk(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
        O_DECODE = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        O_LOAD2  = mk(0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0);
        O_STORE2 = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        O_MOVE   = mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        O_BR     = mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        O_HALT   = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);

        add("nop",        I_NOP,    0, 0, 2, O_NONE, O_NONE);
        add("unknown",    decoded_instruction_type'(4'hE), 0, 0, 2, O_NONE, O_NONE);
        add("load",       I_LOAD,   0, 0, 4, O_NONE, O_LOAD2);
        add("store",      I_STORE,  0, 0, 4, O_NONE, O_STORE2);
        add("move",       I_MOVE,   1, 1, 3, O_MOVE, O_NONE);
        add("add",        I_ADD,    0, 0, 3, mk(0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0), O_NONE);
        add("sub",        I_SUB,    0, 0, 3, mk(0, 0, 0, 0, 0, 2'b10, 1, 1, 0, 0), O_NONE);
        add("and",        I_AND,    0, 0, 3, mk(0, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0), O_NONE);
        add("or",         I_OR,     0, 0, 3, mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0), O_NONE);
        add("branch",     I_BRANCH, 0, 0, 3, O_BR,   O_NONE);
        add("bzero_z1",   I_BZERO,  1, 0, 3, O_BR,   O_NONE);
        add("bzero_z0",   I_BZERO,  0, 1, 3, O_NONE, O_NONE);
        add("bnzero_z0",  I_BNZERO, 0, 0, 3, O_BR,   O_NONE);
        add("bneg_n1",    I_BNEG,   0, 1, 3, O_BR,   O_NONE);
        add("bnneg_n0",   I_BNNEG,  1, 0, 3, O_BR,   O_NONE);
        add("bnneg_n1",   I_BNNEG,  0, 1, 3, O_NONE, O_NONE);

        bus.decoded_instruction = I_NOP;
        bus.zero_op           = 1'b0;
        bus.neg_op            = 1'b0;
        bus.unsigned_overflow = 1'b0;
        bus.signed_overflow   = 1'b0;

        // Reset held for three cycles; nothing asserted.
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset_outputs", outs(), O_NONE);
        end
        rst_n = 1'b1;
        check("init_after_release", outs(), O_NONE);
        @(negedge clk);
        check("first_fetch", outs(), O_FETCH);

        // Table: each entry starts at a FETCH negedge and ends on the next FETCH.
        for (int i = 0; i < nv; i++) begin
            bus.decoded_instruction = vecs[i].instr;
            bus.zero_op = vecs[i].z;
            bus.neg_op  = vecs[i].n;
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                if (c > 0) @(negedge clk);
                check($sformatf("%s_c%0d", vecs[i].name, c), outs(), vecs[i].exp[c]);
            end
            @(negedge clk);
        end
        check("fetch_after_table", outs(), O_FETCH);

        // Reset arriving in the middle of STORE_2 must kill the write at once.
        bus.decoded_instruction = I_STORE;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("store2_before_abort", outs(), O_STORE2);
        rst_n = 1'b0;
        #1;
        check("store2_async_reset", outs(), O_NONE);
        bus.decoded_instruction = I_NOP;
        @(negedge clk);
        rst_n = 1'b1;
        check("store_abort_init", outs(), O_NONE);
        @(negedge clk);
        check("store_abort_refetch", outs(), O_FETCH);

        // HALT holds for 20 cycles with only halt asserted.
        bus.decoded_instruction = I_HALT;
        @(negedge clk);
        check("halt_decode", outs(), O_DECODE);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("halt_hold_%0d", c), outs(), O_HALT);
        end
        bus.decoded_instruction = I_NOP;
        bus.zero_op = 1'b1;
        @(negedge clk);
        check("halt_ignores_inputs", outs(), O_HALT);

        // Asynchronous reset mid-halt, away from any clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("halt_async_reset", outs(), O_NONE);
        @(negedge clk);
        check("halt_reset_held", outs(), O_NONE);
        rst_n = 1'b1;
        check("halt_release_init", outs(), O_NONE);
        @(negedge clk);
        check("halt_restart_fetch", outs(), O_FETCH);
        @(negedge clk);
        check("halt_restart_decode", outs(), O_DECODE);
        @(negedge clk);
        check("halt_restart_fetch2", outs(), O_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
